// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_pkg: shared definitions for the AXI4 read-channel arbiter.
// Holds the FSM state encoding, the AXI ID values for the two requesters,
// the RRESP codes, the fixed IFU transfer size and a helper that turns
// RRESP into the per-requester error bit.
// No ports; imported with `import axi_rd_pkg::*`.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int   ID_W    = 4;
  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Instruction fetches are always 8-byte transfers.
  localparam logic [2:0] IFU_SIZE = 3'b011;

  // Error whenever the slave answered SLVERR or DECERR (RRESP[1] set).
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
      RESP_SLVERR, RESP_DECERR: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: bundles the IFU/LSU request side and the AXI4 AR/R
// channel of the read arbiter.
// Modports:
//   master - the arbiter's view: takes requests and R data, drives
//            DONE/DATA/ERR, BUSY and the AR channel plus RREADY.
//   slave  - the environment's view: requesters and the AXI slave.
interface axi_rd_arbiter_if
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              IFU_REQ;
  logic [ADDR_W-1:0] IFU_ADDR;
  logic              IFU_DONE;
  logic [DATA_W-1:0] IFU_DATA;
  logic              IFU_ERR;

  logic              LSU_REQ;
  logic [ADDR_W-1:0] LSU_ADDR;
  logic [2:0]        LSU_SIZE;
  logic              LSU_DONE;
  logic [DATA_W-1:0] LSU_DATA;
  logic              LSU_ERR;

  logic              BUSY;

  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARSIZE;
  logic [7:0]        ARLEN;
  logic [ID_W-1:0]   ARID;

  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;

  modport master (
    input  IFU_REQ, IFU_ADDR, LSU_REQ, LSU_ADDR, LSU_SIZE,
           ARREADY, RVALID, RDATA, RRESP, RLAST,
    output IFU_DONE, IFU_DATA, IFU_ERR, LSU_DONE, LSU_DATA, LSU_ERR,
           BUSY, ARVALID, ARADDR, ARSIZE, ARLEN, ARID, RREADY
  );

  modport slave (
    output IFU_REQ, IFU_ADDR, LSU_REQ, LSU_ADDR, LSU_SIZE,
           ARREADY, RVALID, RDATA, RRESP, RLAST,
    input  IFU_DONE, IFU_DATA, IFU_ERR, LSU_DONE, LSU_DATA, LSU_ERR,
           BUSY, ARVALID, ARADDR, ARSIZE, ARLEN, ARID, RREADY
  );

endinterface

// File: rtl/axi_rd_arbiter_arb_pick.sv
// arb_pick: combinational two-way picker for the read arbiter.
// Ports:
//   req[1:0]   - request vector, bit index = master id (0 IFU, 1 LSU)
//   last_grant - id of the requester granted last time
//   gnt[1:0]   - one-hot grant, same bit order as req
// Macro ARB_RR_EN: defined -> round-robin on simultaneous requests,
// undefined -> fixed priority with LSU ahead of IFU (last_grant ignored).
module arb_pick
  import axi_rd_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifdef ARB_RR_EN
  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == MID_IFU) ? 2'b10 : 2'b01;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt = 2'b00;
    if (req[MID_LSU]) begin
      gnt = 2'b10;
    end else if (req[MID_IFU]) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read channel between the instruction
// fetch unit and the load/store unit. One single-beat read is outstanding
// at a time; the winner gets DATA/ERR and a one-cycle DONE pulse.
// Ports:
//   clk - core clock, rising edge
//   rst - asynchronous, active-low reset
//   bus - axi_rd_arbiter_if.master (requester side + AXI AR/R channel)
// Macro ARB_RR_EN: round-robin arbitration with a last-grant pointer;
// undefined gives fixed LSU-over-IFU priority.
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
)(
  input  logic              clk,
  input  logic              rst,
  axi_rd_arbiter_if.master  bus
);

  state_t            state_q, state_d;
  logic              win_id_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arsize_q;
  logic [DATA_W-1:0] ifu_data_q, lsu_data_q;
  logic              ifu_err_q, lsu_err_q;

  logic [1:0]        req, gnt;
  logic              last_grant;
  logic              grant_id;

  assign req      = {bus.LSU_REQ, bus.IFU_REQ};
  assign grant_id = gnt[MID_LSU] ? MID_LSU : MID_IFU;

`ifdef ARB_RR_EN
  // Pointer starts as "LSU served last" so IFU is preferred after reset.
  logic last_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= MID_LSU;
    end else if (state_q == ST_IDLE && |req) begin
      last_q <= grant_id;
    end
  end
  assign last_grant = last_q;
`else
  assign last_grant = MID_LSU;
`endif

  arb_pick u_arb_pick (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ARVALID is high for the whole ADDR state, so ARREADY alone completes AR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req)                     state_d = ST_ADDR;
      ST_ADDR: if (bus.ARREADY)              state_d = ST_DATA;
      ST_DATA: if (bus.RVALID && bus.RLAST)  state_d = ST_DONE;
      ST_DONE:                               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // The AR fields are latched once at grant time so they cannot move
  // while ARVALID is waiting for ARREADY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_id_q <= MID_IFU;
      araddr_q <= '0;
      arsize_q <= '0;
    end else if (state_q == ST_IDLE && |req) begin
      win_id_q <= grant_id;
      araddr_q <= gnt[MID_LSU] ? bus.LSU_ADDR : bus.IFU_ADDR;
      arsize_q <= gnt[MID_LSU] ? bus.LSU_SIZE : IFU_SIZE;
    end
  end

  // Each accepted beat overwrites the winner's result; the loser's result
  // is left untouched so it keeps showing its own last completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_data_q <= '0;
      ifu_err_q  <= 1'b0;
      lsu_data_q <= '0;
      lsu_err_q  <= 1'b0;
    end else if (state_q == ST_DATA && bus.RVALID) begin
      if (win_id_q == MID_LSU) begin
        lsu_data_q <= bus.RDATA;
        lsu_err_q  <= resp_is_err(bus.RRESP);
      end else begin
        ifu_data_q <= bus.RDATA;
        ifu_err_q  <= resp_is_err(bus.RRESP);
      end
    end
  end

  // Outputs decode only from registers, so there is no path from REQ.
  always_comb begin
    bus.ARVALID  = (state_q == ST_ADDR);
    bus.RREADY   = (state_q == ST_DATA);
    bus.BUSY     = (state_q != ST_IDLE);
    bus.IFU_DONE = (state_q == ST_DONE) && (win_id_q == MID_IFU);
    bus.LSU_DONE = (state_q == ST_DONE) && (win_id_q == MID_LSU);
    bus.ARADDR   = araddr_q;
    bus.ARSIZE   = arsize_q;
    bus.ARLEN    = 8'd0;
    bus.ARID     = {{(ID_W-1){1'b0}}, win_id_q};
    bus.IFU_DATA = ifu_data_q;
    bus.IFU_ERR  = ifu_err_q;
    bus.LSU_DATA = lsu_data_q;
    bus.LSU_ERR  = lsu_err_q;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the core's single AXI4 read channel (AR/R) between the instruction fetch unit and the load/store unit. Accepts one read request per requester, grants exactly one, drives a single-beat AXI4 read, and returns data, error status and a one-cycle done pulse to the granted requester. Sits between IFU/LSU and the AXI4 master port; only one transaction is outstanding at any time.

## Interface
- ADDR_W, 64, address width of requesters and ARADDR
- DATA_W, 64, data width of RDATA and returned data
- clk  in  1  core clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- IFU_REQ  in  1  fetch read request, held until IFU_DONE
- IFU_ADDR  in  ADDR_W  fetch address, stable while IFU_REQ high
- IFU_DONE  out  1  one-cycle pulse, IFU_DATA/IFU_ERR valid
- IFU_DATA  out  DATA_W  returned fetch data
- IFU_ERR  out  1  RRESP[1] of the fetch beat
- LSU_REQ  in  1  load read request, held until LSU_DONE
- LSU_ADDR  in  ADDR_W  load address
- LSU_SIZE  in  3  AXI ARSIZE encoding for the load
- LSU_DONE / LSU_DATA / LSU_ERR  out  1/DATA_W/1  as IFU counterparts
- BUSY  out  1  high whenever state is not IDLE
- ARVALID  out  1, ARREADY  in  1, ARADDR  out  ADDR_W, ARSIZE  out  3, ARLEN  out  8 (constant 0), ARID  out  4 (0 = IFU, 1 = LSU)
- RVALID  in  1, RREADY  out  1, RDATA  in  DATA_W, RRESP  in  2, RLAST  in  1

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: if any REQ high, pick winner, latch winner id, address, size (IFU size fixed 3'b011); next ADDR.
- ADDR: ARVALID=1, AR fields stable from latched registers; on ARVALID&&ARREADY -> DATA.
- DATA: RREADY=1; every RVALID beat overwrites data/err registers; on RVALID&&RLAST -> DONE.
- DONE: winner's DONE=1 for exactly this cycle with captured DATA/ERR; loser DONE=0; next IDLE.
- Arbitration only in IDLE; a request arriving mid-transaction waits.
- REQ dropped mid-transaction: transaction still completes and DONE still pulses.
- RVALID while in IDLE/ADDR ignored (RREADY=0).
- DATA/ERR outputs hold last captured value until next completion.
- Reset (any state, any time): state IDLE; ARVALID, RREADY, BUSY, both DONE, both ERR, ARADDR, ARSIZE, ARID, DATA outputs = 0; RR pointer = IFU-preferred.

## Timing
- REQ seen in IDLE at cycle 0 -> ARVALID high cycle 1.
- ARREADY high cycle 1 -> RREADY high cycle 2; RVALID&&RLAST cycle 2 -> DONE cycle 3. Minimum latency 3 cycles request-to-done.
- DONE cycle then IDLE: back-to-back grants separated by one IDLE cycle; minimum request spacing 4 cycles.
- ARVALID never deasserts before ARREADY; AR fields never change while ARVALID high.
- All outputs registered; no combinational path REQ -> ARVALID.

## Configuration
- ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not granted last; pointer updates on entering ADDR.
- ARB_RR_EN undefined: fixed priority, LSU wins over IFU on simultaneous requests; no pointer register.

## Structure
- Package axi_rd_pkg: state encoding, master id constants (MID_IFU=0, MID_LSU=1), RRESP codes (OKAY, EXOKAY, SLVERR, DECERR), IFU fixed size constant.
- Sub-module arb_pick: combinational two-way picker (req vector, last-grant in) -> one-hot grant; priority or RR chosen by ARB_RR_EN.

## Test plan
- IFU_REQ alone, addr 0x8000_0000, ARREADY/RVALID immediate, RDATA 0x00000013_00000297 -> ARID 0, IFU_DONE cycle 3 with that data, IFU_ERR 0.
- IFU and LSU request same cycle, LSU_ADDR 0x8000_1000 size 2 -> without ARB_RR_EN LSU first then IFU; with ARB_RR_EN after reset IFU first, next pair LSU first.
- ARREADY delayed 5 cycles -> ARVALID/ARADDR/ARSIZE constant 5 cycles, DONE at cycle 8.
- RRESP=2'b10 on LSU read -> LSU_ERR 1 with LSU_DONE, IFU_DONE stays 0.
- rst low during DATA with RVALID pending -> same-cycle IDLE, all outputs 0; post-reset IFU read completes normally.
- LSU_REQ dropped in ADDR state -> transaction finishes, LSU_DONE pulses once, then IDLE.
